fetch_control: RTL and testbench
================================

Name: fetch_control

Overview:
- FSM sequencer for the 8-bit fetch unit.
- Drives the fetch unit's start/start_addr, halt, branch/taken/target controls from a boot request, instruction-memory readiness, hazard stalls, branch resolution and decoded HALT.
- Provides run status, cycle/instruction counters and a stall watchdog. Sits between core top-level control and the fetch unit.

Parameters:
- CNT_W, 16, width of cycle_cnt_o and instr_cnt_o; counters saturate at all-ones.
- STALL_MAX, 64, consecutive WAIT cycles that trip the watchdog into ERROR; legal range 1..255.
- FLUSH_CYC, 1, bubble cycles (halt asserted) after a taken branch; legal range 0..3.

Ports:
- f_clk  in  1  clock, rising-edge.
- f_rst_n  in  1  asynchronous, active-low reset.
- go_i  in  1  level; sampled in IDLE/DONE/ERROR to boot.
- boot_addr_i  in  8  boot PC.
- imem_ready_i  in  1  instruction memory can accept a fetch this cycle.
- stall_i  in  1  pipeline hazard stall.
- br_valid_i  in  1  branch resolved this cycle.
- br_taken_i  in  1  resolved branch is taken; qualified by br_valid_i.
- br_target_i  in  8  branch target.
- halt_instr_i  in  1  decoded HALT instruction.
- pc_i  in  8  current PC from the fetch unit.
- start_o  out  1  fetch unit start.
- start_addr_o  out  8  fetch unit start address.
- halt_o  out  1  freeze fetch unit.
- branch_o  out  1  branch resolved, to fetch unit.
- taken_o  out  1  redirect to target_o.
- target_o  out  8  redirect address.
- running_o  out  1  state is RUN, WAIT or FLUSH.
- done_o  out  1  state is DONE.
- error_o  out  1  state is ERROR.
- halt_pc_o  out  8  pc_i captured on HALT or watchdog trip.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN, WAIT and FLUSH.
- instr_cnt_o  out  CNT_W  RUN cycles with halt_o=0.

Behaviour:
- States: IDLE, BOOT, RUN, WAIT, FLUSH, DONE, ERROR.
- Reset (async, f_rst_n=0):
  - state=IDLE.
  - All counters and halt_pc_o = 0.
  - Internal flush and watchdog counters = 0.
  - Outputs take their IDLE values.
- Outputs are combinational from state plus inputs; all state and counters are registered.
- Default output values: start_o=0, start_addr_o=boot_addr_i, halt_o=1, branch_o=0, taken_o=0, target_o=br_target_i.
- IDLE:
  - go_i=1 -> BOOT.
  - On that transition, clear cycle_cnt, instr_cnt and halt_pc.
- BOOT (exactly 1 cycle):
  - start_o=1, halt_o=0.
  - Next state RUN.
- RUN, evaluated in priority order:
  1. halt_instr_i=1 -> DONE; halt_o=1; capture pc_i into halt_pc_o.
  2. stall_i=1 or imem_ready_i=0 -> WAIT; halt_o=1; watchdog count=1.
  3. br_valid_i=1:
     - halt_o=0, branch_o=1, taken_o=br_taken_i.
     - If br_taken_i=1 and FLUSH_CYC>0 -> FLUSH, flush count=FLUSH_CYC; otherwise stay in RUN.
  4. Otherwise stay in RUN with halt_o=0.
- WAIT:
  - halt_o=1; branch inputs are ignored.
  - Exit to RUN when stall_i=0 and imem_ready_i=1; halt_instr_i=1 takes priority and goes to DONE.
  - Watchdog increments each WAIT cycle. When it reaches STALL_MAX while still stalled -> ERROR, capturing pc_i.
  - Watchdog clears on leaving WAIT.
- FLUSH:
  - halt_o=1; flush count decrements each cycle.
  - When the count reaches 0 -> RUN.
  - halt_instr_i is ignored here because the instruction is on the wrong path.
- DONE and ERROR:
  - halt_o=1.
  - Counters and halt_pc_o hold their values.
  - go_i=1 -> BOOT, clearing counters.
- cycle_cnt increments in RUN, WAIT and FLUSH (not in BOOT). Both counters saturate.
- Simultaneous events:
  - go_i is ignored outside IDLE, DONE and ERROR.
  - In RUN, a branch arriving together with a stall is dropped. The resolving stage must hold br_valid_i until it is accepted, i.e. until a RUN cycle with halt_o=0.
- Reset asserted mid-run aborts immediately to IDLE; no completion pulse is generated.

Test Plan:
- Reset, then go_i=1 with boot_addr_i=0x10 -> BOOT for 1 cycle with start_o=1, start_addr_o=0x10, then RUN; after 5 clean cycles instr_cnt_o=5 and cycle_cnt_o=5.
- In RUN, br_valid_i=1, br_taken_i=1, br_target_i=0x40 with FLUSH_CYC=1 -> taken_o=1, target_o=0x40 for one cycle, then one FLUSH cycle with halt_o=1, then RUN; the FLUSH cycle counts in cycle_cnt_o but not in instr_cnt_o.
- In RUN, imem_ready_i=0 for 3 cycles -> WAIT with halt_o=1 for 3 cycles, return to RUN; cycle_cnt_o increases by 3 and instr_cnt_o is unchanged.
- With STALL_MAX=4, hold stall_i=1 indefinitely with pc_i=0x22 -> ERROR after the 4th WAIT cycle; error_o=1 and halt_pc_o=0x22; then go_i=1 -> BOOT with counters cleared.
- halt_instr_i=1 together with br_valid_i=1 in RUN at pc_i=0x35 -> DONE, done_o=1, halt_pc_o=0x35, taken_o=0.
- f_rst_n=0 asserted mid-WAIT -> immediately IDLE with all outputs at reset values and counters 0; no done_o or error_o pulse.

Source files
------------

// File: rtl/fetch_control.sv
// fetch_control: sequencer for the 8-bit fetch unit.
//   Boots the fetch unit on go_i, then holds it in RUN, parks it in WAIT on
//   hazard/imem back-pressure, inserts FLUSH bubbles after taken branches and
//   stops in DONE on a decoded HALT (or ERROR when the stall watchdog trips).
//
// State table:
//   state   | meaning
//   IDLE    | out of reset, fetch unit frozen, waiting for go_i
//   BOOT    | one-cycle start pulse to the fetch unit at boot_addr_i
//   RUN     | fetching; branches forwarded to the fetch unit
//   WAIT    | fetch frozen by stall_i or !imem_ready_i; watchdog counting
//   FLUSH   | bubble cycles after a taken branch
//   DONE    | HALT retired; counters and halt_pc_o held
//   ERROR   | watchdog expired; counters and halt_pc_o held
//
// Ports:
//   f_clk, f_rst_n          clock, async active-low reset
//   go_i, boot_addr_i       boot request and boot PC
//   imem_ready_i, stall_i   fetch back-pressure
//   br_valid_i/taken/target branch resolution
//   halt_instr_i, pc_i      decoded HALT and current PC
//   start_o, start_addr_o   fetch unit start
//   halt_o                  fetch unit freeze
//   branch_o/taken_o/target_o  redirect to fetch unit
//   running_o/done_o/error_o   status
//   halt_pc_o               PC captured on HALT or watchdog trip
//   cycle_cnt_o/instr_cnt_o saturating activity counters
module fetch_control #(
  parameter int CNT_W     = 16,
  parameter int STALL_MAX = 64,
  parameter int FLUSH_CYC = 1
) (
  input  logic             f_clk,
  input  logic             f_rst_n,
  input  logic             go_i,
  input  logic [7:0]       boot_addr_i,
  input  logic             imem_ready_i,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic             br_taken_i,
  input  logic [7:0]       br_target_i,
  input  logic             halt_instr_i,
  input  logic [7:0]       pc_i,
  output logic             start_o,
  output logic [7:0]       start_addr_o,
  output logic             halt_o,
  output logic             branch_o,
  output logic             taken_o,
  output logic [7:0]       target_o,
  output logic             running_o,
  output logic             done_o,
  output logic             error_o,
  output logic [7:0]       halt_pc_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BOOT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [7:0]       WD_MAX     = 8'(STALL_MAX);
  localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYC);

  logic [2:0]       state_q, state_d;
  logic [7:0]       wd_q, wd_d;
  logic [1:0]       fc_q, fc_d;
  logic [7:0]       halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0] cycle_q, instr_q;
  logic             clear_cnt, cyc_inc, instr_inc;
  logic             fetch_ok;

  assign fetch_ok = imem_ready_i & ~stall_i;

  always_comb begin
    start_o      = 1'b0;
    start_addr_o = boot_addr_i;
    halt_o       = 1'b1;
    branch_o     = 1'b0;
    taken_o      = 1'b0;
    target_o     = br_target_i;
    state_d      = state_q;
    wd_d         = wd_q;
    fc_d         = fc_q;
    halt_pc_d    = halt_pc_q;
    clear_cnt    = 1'b0;
    cyc_inc      = 1'b0;
    instr_inc    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go_i) begin
          state_d   = S_BOOT;
          clear_cnt = 1'b1;
          halt_pc_d = 8'h00;
        end
      end
      S_BOOT: begin
        start_o = 1'b1;
        halt_o  = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cyc_inc = 1'b1;
        if (halt_instr_i) begin
          state_d   = S_DONE;
          halt_pc_d = pc_i;
        end else if (!fetch_ok) begin
          // a branch arriving with a stall is dropped; the resolver holds it
          state_d = S_WAIT;
          wd_d    = 8'd1;
        end else begin
          halt_o    = 1'b0;
          instr_inc = 1'b1;
          if (br_valid_i) begin
            branch_o = 1'b1;
            taken_o  = br_taken_i;
            if (br_taken_i && (FLUSH_CYC != 0)) begin
              state_d = S_FLUSH;
              fc_d    = FLUSH_INIT;
            end
          end
        end
      end
      S_WAIT: begin
        cyc_inc = 1'b1;
        if (halt_instr_i) begin
          state_d   = S_DONE;
          halt_pc_d = pc_i;
          wd_d      = 8'd0;
        end else if (fetch_ok) begin
          state_d = S_RUN;
          wd_d    = 8'd0;
        end else if (wd_q >= WD_MAX) begin
          state_d   = S_ERROR;
          halt_pc_d = pc_i;
          wd_d      = 8'd0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      S_FLUSH: begin
        cyc_inc = 1'b1;
        if (fc_q <= 2'd1) begin
          state_d = S_RUN;
          fc_d    = 2'd0;
        end else begin
          fc_d = fc_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge f_clk or negedge f_rst_n) begin
    if (!f_rst_n) begin
      state_q   <= S_IDLE;
      wd_q      <= 8'd0;
      fc_q      <= 2'd0;
      halt_pc_q <= 8'd0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      fc_q      <= fc_d;
      halt_pc_q <= halt_pc_d;
      if (clear_cnt) begin
        cycle_q <= '0;
        instr_q <= '0;
      end else begin
        if (cyc_inc && (cycle_q != CNT_MAX))
          cycle_q <= cycle_q + 1'b1;
        if (instr_inc && (instr_q != CNT_MAX))
          instr_q <= instr_q + 1'b1;
      end
    end
  end

  assign running_o   = (state_q == S_RUN) | (state_q == S_WAIT) | (state_q == S_FLUSH);
  assign done_o      = (state_q == S_DONE);
  assign error_o     = (state_q == S_ERROR);
  assign halt_pc_o   = halt_pc_q;
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;

endmodule

// File: tb/tb_fetch_control.sv
module tb_fetch_control;
  localparam int CW   = 8;
  localparam int SMAX = 4;
  localparam int FCYC = 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          f_clk = 1'b0;
  logic          f_rst_n;
  logic          go_i, imem_ready_i, stall_i, br_valid_i, br_taken_i, halt_instr_i;
  logic [7:0]    boot_addr_i, br_target_i, pc_i;
  logic          start_o, halt_o, branch_o, taken_o, running_o, done_o, error_o;
  logic [7:0]    start_addr_o, target_o, halt_pc_o;
  logic [CW-1:0] cycle_cnt_o, instr_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_control #(.CNT_W(CW), .STALL_MAX(SMAX), .FLUSH_CYC(FCYC)) dut (
    .f_clk(f_clk), .f_rst_n(f_rst_n), .go_i(go_i), .boot_addr_i(boot_addr_i),
    .imem_ready_i(imem_ready_i), .stall_i(stall_i), .br_valid_i(br_valid_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i), .halt_instr_i(halt_instr_i),
    .pc_i(pc_i), .start_o(start_o), .start_addr_o(start_addr_o), .halt_o(halt_o),
    .branch_o(branch_o), .taken_o(taken_o), .target_o(target_o),
    .running_o(running_o), .done_o(done_o), .error_o(error_o), .halt_pc_o(halt_pc_o),
    .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 f_clk = ~f_clk;

  // Reference model: operating mode plus unbounded activity tallies.
  typedef enum {M_IDLE, M_BOOT, M_RUN, M_WAIT, M_FLUSH, M_DONE, M_ERR} mode_t;
  mode_t m_mode;
  int    m_cycles, m_instrs, m_stall_len, m_flush_left;
  logic [7:0] m_halt_pc;

  always @(posedge f_clk or negedge f_rst_n) begin
    if (!f_rst_n) begin
      m_mode <= M_IDLE; m_cycles <= 0; m_instrs <= 0;
      m_stall_len <= 0; m_flush_left <= 0; m_halt_pc <= 8'h00;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE, M_ERR:
          if (go_i) begin
            m_mode <= M_BOOT; m_cycles <= 0; m_instrs <= 0; m_halt_pc <= 8'h00;
          end
        M_BOOT: m_mode <= M_RUN;
        M_RUN: begin
          m_cycles <= m_cycles + 1;
          if (halt_instr_i) begin
            m_mode <= M_DONE; m_halt_pc <= pc_i;
          end else if (stall_i || !imem_ready_i) begin
            m_mode <= M_WAIT; m_stall_len <= 1;
          end else begin
            m_instrs <= m_instrs + 1;
            if (br_valid_i && br_taken_i && FCYC > 0) begin
              m_mode <= M_FLUSH; m_flush_left <= FCYC;
            end
          end
        end
        M_WAIT: begin
          m_cycles <= m_cycles + 1;
          if (halt_instr_i) begin
            m_mode <= M_DONE; m_halt_pc <= pc_i;
          end else if (!stall_i && imem_ready_i) begin
            m_mode <= M_RUN;
          end else if (m_stall_len == SMAX) begin
            m_mode <= M_ERR; m_halt_pc <= pc_i;
          end else begin
            m_stall_len <= m_stall_len + 1;
          end
        end
        M_FLUSH: begin
          m_cycles <= m_cycles + 1;
          m_flush_left <= m_flush_left - 1;
          if (m_flush_left == 1) m_mode <= M_RUN;
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  function automatic logic [CW-1:0] sat(int v);
    return (v > CMAX) ? CW'(CMAX) : CW'(v);
  endfunction

  function automatic logic [46:0] model_outs();
    logic st, hl, br, tk, run, dn, er;
    st  = (m_mode == M_BOOT);
    hl  = !((m_mode == M_BOOT) ||
            (m_mode == M_RUN && !halt_instr_i && !stall_i && imem_ready_i));
    br  = (m_mode == M_RUN) && !hl && br_valid_i;
    tk  = br && br_taken_i;
    run = (m_mode == M_RUN) || (m_mode == M_WAIT) || (m_mode == M_FLUSH);
    dn  = (m_mode == M_DONE);
    er  = (m_mode == M_ERR);
    return {st, boot_addr_i, hl, br, tk, br_target_i, run, dn, er, m_halt_pc,
            sat(m_cycles), sat(m_instrs)};
  endfunction

  task automatic cyc();
    @(posedge f_clk);
    #1;
  endtask

  task automatic idle_inputs();
    go_i = 0; boot_addr_i = 8'h00; imem_ready_i = 1; stall_i = 0;
    br_valid_i = 0; br_taken_i = 0; br_target_i = 8'h00; halt_instr_i = 0; pc_i = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    f_rst_n = 0;
    cyc(); cyc();
    #1;
    n_cmp++; if (halt_o !== 1'b1) begin n_bad++; $display("FAIL reset_halt: got %b expected 1", halt_o); end
    n_cmp++; if ({start_o, running_o, done_o, error_o} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_status: got %b expected 0000", {start_o, running_o, done_o, error_o}); end
    n_cmp++; if ({cycle_cnt_o, instr_cnt_o, halt_pc_o} !== '0) begin n_bad++;
      $display("FAIL reset_counters: got %h/%h/%h expected 0", cycle_cnt_o, instr_cnt_o, halt_pc_o); end
    @(posedge f_clk); #1;
    f_rst_n = 1;
    cyc();
  endtask

  task automatic test_boot_run();
    go_i = 1; boot_addr_i = 8'h10;
    cyc();
    go_i = 0;
    #1;
    n_cmp++; if ({start_o, start_addr_o, halt_o} !== {1'b1, 8'h10, 1'b0}) begin n_bad++;
      $display("FAIL boot_start: got start=%b addr=%h halt=%b expected 1 10 0", start_o, start_addr_o, halt_o); end
    cyc();
    n_cmp++; if ({running_o, start_o} !== 2'b10) begin n_bad++;
      $display("FAIL boot_to_run: got running=%b start=%b expected 1 0", running_o, start_o); end
    repeat (5) cyc();
    n_cmp++; if (instr_cnt_o !== 8'd5 || cycle_cnt_o !== 8'd5) begin n_bad++;
      $display("FAIL run5_counts: got instr=%0d cycle=%0d expected 5 5", instr_cnt_o, cycle_cnt_o); end
  endtask

  task automatic test_branch();
    br_valid_i = 1; br_taken_i = 1; br_target_i = 8'h40;
    #1;
    n_cmp++; if ({branch_o, taken_o, target_o, halt_o} !== {1'b1, 1'b1, 8'h40, 1'b0}) begin n_bad++;
      $display("FAIL branch_redirect: got br=%b tk=%b tgt=%h halt=%b expected 1 1 40 0",
               branch_o, taken_o, target_o, halt_o); end
    cyc();
    br_valid_i = 0; br_taken_i = 0;
    #1;
    n_cmp++; if ({halt_o, running_o, taken_o} !== 3'b110) begin n_bad++;
      $display("FAIL flush_bubble: got halt=%b run=%b tk=%b expected 1 1 0", halt_o, running_o, taken_o); end
    cyc();
    n_cmp++; if (halt_o !== 1'b0 || cycle_cnt_o !== 8'd7 || instr_cnt_o !== 8'd6) begin n_bad++;
      $display("FAIL after_flush: got halt=%b cycle=%0d instr=%0d expected 0 7 6", halt_o, cycle_cnt_o, instr_cnt_o); end
  endtask

  task automatic test_wait();
    logic [CW-1:0] i0;
    int halted;
    i0 = instr_cnt_o;
    halted = 0;
    imem_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (halt_o) halted++;
      cyc();
    end
    imem_ready_i = 1;
    #1;
    n_cmp++; if (halted != 3 || halt_o !== 1'b1 || running_o !== 1'b1) begin n_bad++;
      $display("FAIL wait_halt: got halted=%0d halt=%b run=%b expected 3 1 1", halted, halt_o, running_o); end
    cyc();
    n_cmp++; if (halt_o !== 1'b0) begin n_bad++; $display("FAIL wait_exit: got halt=%b expected 0", halt_o); end
    n_cmp++; if (instr_cnt_o !== i0 || cycle_cnt_o !== sat(m_cycles)) begin n_bad++;
      $display("FAIL wait_counts: got instr=%0d cycle=%0d expected %0d %0d", instr_cnt_o, cycle_cnt_o, i0, sat(m_cycles)); end
  endtask

  task automatic test_watchdog();
    int waits;
    stall_i = 1; pc_i = 8'h22;
    cyc();
    waits = 0;
    for (int k = 0; k < 20 && !error_o; k++) begin
      if (running_o) waits++;
      cyc();
    end
    n_cmp++; if (error_o !== 1'b1 || waits != SMAX) begin n_bad++;
      $display("FAIL watchdog_trip: got error=%b waits=%0d expected 1 %0d", error_o, waits, SMAX); end
    n_cmp++; if (halt_pc_o !== 8'h22 || running_o !== 1'b0 || halt_o !== 1'b1) begin n_bad++;
      $display("FAIL watchdog_pc: got pc=%h run=%b halt=%b expected 22 0 1", halt_pc_o, running_o, halt_o); end
    stall_i = 0; go_i = 1;
    cyc();
    go_i = 0;
    #1;
    n_cmp++; if ({start_o, cycle_cnt_o, instr_cnt_o, halt_pc_o} !== {1'b1, 24'h0}) begin n_bad++;
      $display("FAIL reboot_clear: got start=%b cyc=%0d ins=%0d pc=%h expected 1 0 0 00",
               start_o, cycle_cnt_o, instr_cnt_o, halt_pc_o); end
    cyc();
    repeat (2) cyc();
  endtask

  task automatic test_halt_branch();
    logic [CW-1:0] c0, i0;
    pc_i = 8'h35; halt_instr_i = 1; br_valid_i = 1; br_taken_i = 1; br_target_i = 8'h77;
    #1;
    n_cmp++; if ({taken_o, branch_o, halt_o} !== 3'b001) begin n_bad++;
      $display("FAIL halt_vs_branch: got tk=%b br=%b halt=%b expected 0 0 1", taken_o, branch_o, halt_o); end
    cyc();
    halt_instr_i = 0; br_valid_i = 0; br_taken_i = 0;
    #1;
    n_cmp++; if (done_o !== 1'b1 || halt_pc_o !== 8'h35 || running_o !== 1'b0) begin n_bad++;
      $display("FAIL halt_done: got done=%b pc=%h run=%b expected 1 35 0", done_o, halt_pc_o, running_o); end
    c0 = cycle_cnt_o; i0 = instr_cnt_o;
    halt_instr_i = 1; pc_i = 8'h99;
    repeat (3) cyc();
    halt_instr_i = 0;
    n_cmp++; if (cycle_cnt_o !== c0 || instr_cnt_o !== i0 || halt_pc_o !== 8'h35) begin n_bad++;
      $display("FAIL done_hold: got %0d %0d %h expected %0d %0d 35", cycle_cnt_o, instr_cnt_o, halt_pc_o, c0, i0); end
  endtask

  task automatic test_saturation();
    go_i = 1;
    cyc();
    go_i = 0;
    cyc();
    repeat (CMAX + 40) cyc();
    n_cmp++; if (cycle_cnt_o !== CW'(CMAX) || instr_cnt_o !== CW'(CMAX)) begin n_bad++;
      $display("FAIL saturate: got cycle=%0d instr=%0d expected %0d %0d", cycle_cnt_o, instr_cnt_o, CMAX, CMAX); end
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    imem_ready_i = 0;
    cyc(); cyc();
    f_rst_n = 0;
    #1;
    n_cmp++; if ({running_o, done_o, error_o, halt_o, start_o} !== 5'b00010) begin n_bad++;
      $display("FAIL rst_mid_status: got %b expected 00010", {running_o, done_o, error_o, halt_o, start_o}); end
    n_cmp++; if ({cycle_cnt_o, instr_cnt_o, halt_pc_o} !== '0) begin n_bad++;
      $display("FAIL rst_mid_counters: got %h/%h/%h expected 0", cycle_cnt_o, instr_cnt_o, halt_pc_o); end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      if (done_o || error_o) pulses++;
      cyc();
    end
    f_rst_n = 1; imem_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      if (done_o || error_o || running_o) pulses++;
      cyc();
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL rst_no_pulse: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_random();
    logic [46:0] got, exp;
    int shown;
    shown = 0;
    for (int k = 0; k < 3000; k++) begin
      go_i         = ($urandom_range(0, 99) < 30);
      boot_addr_i  = 8'($urandom);
      imem_ready_i = ($urandom_range(0, 99) >= 20);
      stall_i      = ($urandom_range(0, 99) < 15);
      br_valid_i   = ($urandom_range(0, 99) < 25);
      br_taken_i   = $urandom_range(0, 1) == 1;
      br_target_i  = 8'($urandom);
      halt_instr_i = ($urandom_range(0, 99) < 3);
      pc_i         = 8'($urandom);
      #1;
      exp = model_outs();
      got = {start_o, start_addr_o, halt_o, branch_o, taken_o, target_o, running_o,
             done_o, error_o, halt_pc_o, cycle_cnt_o, instr_cnt_o};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle%0d: got %h expected %h", k, got, exp);
        end
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_branch();
    test_wait();
    test_watchdog();
    test_halt_branch();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
